// File: rtl/sha256_block_writer_if.sv
// Request/response register bus between the block writer (master) and a sha256 register slave.
// One write request is outstanding at a time; the response carries only an error flag.
interface sha256_block_writer_if #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataBytes = DataWidth / 8
);
   logic [DataWidth-1:0] reqdata;
   logic [AddrWidth-1:0] reqaddr;
   logic                 reqvalid;
   logic                 reqwrite;
   logic                 reqready;
   logic [DataBytes-1:0] reqstrobe;
   logic                 rspready;
   logic                 rspvalid;
   logic [DataWidth-1:0] rspdata;
   logic                 rsperror;

   modport master (
      output reqdata, reqaddr, reqvalid, reqwrite, reqstrobe, rspready,
      input  reqready, rspvalid, rspdata, rsperror
   );

   modport slave (
      input  reqdata, reqaddr, reqvalid, reqwrite, reqstrobe, rspready,
      output reqready, rspvalid, rspdata, rsperror
   );
endinterface

// File: rtl/sha256_block_writer.sv
// Writes one message block word-by-word into a sha256 register slave, starts the core,
// collects and acknowledges the digest, then hands it upstream.
module sha256_block_writer #(
   parameter int unsigned DataWidth     = 64,
   parameter int unsigned AddrWidth     = 32,
   parameter int unsigned DataBytes     = DataWidth / 8,
   parameter int unsigned BlockWidth    = 512,
   parameter logic [AddrWidth-1:0] BaseAddr = '0,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [BlockWidth-1:0] blk_data_i,
   input  logic                  blk_valid_i,
   output logic                  blk_ready_o,
   sha256_block_writer_if.master m,
   output logic                  sha_process_o,
   input  logic [255:0]          sha_digest_i,
   input  logic                  sha_digestvalid_i,
   output logic                  sha_digestack_o,
   output logic [255:0]          digest_o,
   output logic                  digest_valid_o,
   input  logic                  digest_ready_i,
   output logic                  err_o
);

   localparam int unsigned NumWords = BlockWidth / DataWidth;
   localparam int unsigned KW       = (NumWords > 1) ? $clog2(NumWords) : 1;
   localparam int unsigned TW       = $clog2(TimeoutCycles + 1);

   typedef enum logic [2:0] {
      StIdle, StReq, StRsp, StProc, StWaitDig, StAck, StOut
   } state_e;

   state_e                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [TW-1:0]         tcnt_q, tcnt_d;
   logic [BlockWidth-1:0] blk_q, blk_d;
   logic [255:0]          digest_q, digest_d;
   logic                  err_q, err_d;

   logic                  timed_out;
   logic [TW-1:0]         tcnt_inc;
   logic                  in_req;
   logic                  unused_rspdata;

   assign unused_rspdata = ^m.rspdata;

   // Expiry is judged on the last waiting cycle so the awaited event still wins a tie.
   assign timed_out = (tcnt_q >= TW'(TimeoutCycles - 1));
   assign tcnt_inc  = (tcnt_q == TW'(TimeoutCycles)) ? tcnt_q : tcnt_q + TW'(1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         k_q      <= '0;
         tcnt_q   <= '0;
         blk_q    <= '0;
         digest_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         tcnt_q   <= tcnt_d;
         blk_q    <= blk_d;
         digest_q <= digest_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      tcnt_d   = tcnt_q;
      blk_d    = blk_q;
      digest_d = digest_q;
      err_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (blk_valid_i) begin
               blk_d   = blk_data_i;
               k_d     = '0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (m.reqready) begin
               tcnt_d  = '0;
               state_d = StRsp;
            end
         end
         StRsp: begin
            if (m.rspvalid) begin
               if (m.rsperror) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else if (k_q == KW'(NumWords - 1)) begin
                  state_d = StProc;
               end else begin
                  k_d     = k_q + KW'(1);
                  state_d = StReq;
               end
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         StProc: begin
            tcnt_d  = '0;
            state_d = StWaitDig;
         end
         StWaitDig: begin
            if (sha_digestvalid_i) begin
               digest_d = sha_digest_i;
               state_d  = StAck;
            end else if (timed_out) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               tcnt_d = tcnt_inc;
            end
         end
         StAck: state_d = StOut;
         StOut: begin
            if (digest_ready_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign in_req = (state_q == StReq);

   // Address and data are forced to zero outside REQ so the bus is quiet during reset.
   assign m.reqvalid  = in_req;
   assign m.reqwrite  = in_req;
   assign m.reqstrobe = in_req ? {DataBytes{1'b1}} : '0;
   assign m.reqdata   = in_req ? blk_q[k_q*DataWidth +: DataWidth] : '0;
   assign m.reqaddr   = in_req ? (BaseAddr + AddrWidth'(k_q) * AddrWidth'(DataBytes)) : '0;
   assign m.rspready  = (state_q == StRsp);

   // IDLE is the reset state, so ready is masked by reset to keep it low while held.
   assign blk_ready_o     = (state_q == StIdle) && !rst_i;
   assign sha_process_o   = (state_q == StProc);
   assign sha_digestack_o = (state_q == StAck);
   assign digest_valid_o  = (state_q == StOut);
   assign digest_o        = digest_q;
   assign err_o           = err_q;

endmodule

// File: tb/tb_sha256_block_writer.sv
// Random-stimulus bench for sha256_block_writer: acts as bus responder and sha256 core and
// compares every cycle of each transaction against a per-word expectation model.
module tb_sha256_block_writer;

   localparam int DW = 64;
   localparam int AW = 32;
   localparam int NW = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [511:0] blk_data = '0;
   logic         blk_valid = 1'b0;
   logic         blk_ready;
   logic         sha_process;
   logic [255:0] sha_digest = '0;
   logic         sha_dv = 1'b0;
   logic         sha_ack;
   logic [255:0] digest;
   logic         digest_valid;
   logic         digest_ready = 1'b0;
   logic         err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sha256_block_writer_if #(.DataWidth(DW), .AddrWidth(AW)) bus ();

   sha256_block_writer #(.TimeoutCycles(TO)) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .blk_data_i        (blk_data),
      .blk_valid_i       (blk_valid),
      .blk_ready_o       (blk_ready),
      .m                 (bus),
      .sha_process_o     (sha_process),
      .sha_digest_i      (sha_digest),
      .sha_digestvalid_i (sha_dv),
      .sha_digestack_o   (sha_ack),
      .digest_o          (digest),
      .digest_valid_o    (digest_valid),
      .digest_ready_i    (digest_ready),
      .err_o             (err)
   );

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] word_of(input logic [511:0] b, input int k);
      logic [511:0] t;
      t = b >> (k * DW);
      return t[63:0];
   endfunction

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   function automatic logic [255:0] rand_digest();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic all_zero(input string tag);
      check(tag, {blk_ready, bus.reqdata, bus.reqaddr, bus.reqvalid, bus.reqwrite,
                  bus.reqstrobe, bus.rspready, sha_process, sha_ack, digest, digest_valid, err},
            '0);
   endtask

   // Spurious digest traffic outside WAIT_DIG must have no effect.
   task automatic noise();
      sha_dv     = 1'($urandom_range(0, 1));
      sha_digest = rand_digest();
   endtask

   // Called and returns at a negedge. Negative word indices disable the respective event.
   task automatic run_block(input logic [511:0] blk, input logic [255:0] dig,
                            input int stall_word, input int stall_len, input int err_word,
                            input int rst_word, input int core_lat, input int out_stall,
                            input bit no_dig);
      int guard;
      guard = 0;
      while (!blk_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("blk_ready", blk_ready, 1'b1);
      blk_data  = blk;
      blk_valid = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
      blk_data  = ~blk;
      for (int k = 0; k < NW; k++) begin
         bus.reqready = 1'b0;
         if (k == stall_word) begin
            repeat (stall_len) begin
               noise();
               check("req_hold", {bus.reqvalid, bus.reqaddr, bus.reqdata},
                     {1'b1, 32'(k * 8), word_of(blk, k)});
               @(negedge clk);
            end
         end
         noise();
         check("req", {bus.reqvalid, bus.reqwrite, bus.reqstrobe, bus.reqaddr, bus.reqdata},
               {1'b1, 1'b1, 8'hFF, 32'(k * 8), word_of(blk, k)});
         bus.reqready = 1'b1;
         @(negedge clk);
         bus.reqready = 1'b0;
         check("rsp_wait", {bus.reqvalid, bus.rspready, sha_process}, 3'b010);
         if (k == rst_word) begin
            rst = 1'b1;
            #1;
            all_zero("reset_mid");
            @(negedge clk);
            @(negedge clk);
            rst    = 1'b0;
            sha_dv = 1'b0;
            #1;
            check("restart_idle", {blk_ready, bus.reqvalid}, 2'b10);
            return;
         end
         noise();
         bus.rspvalid = 1'b1;
         bus.rsperror = (k == err_word);
         bus.rspdata  = {$urandom, $urandom};
         @(negedge clk);
         bus.rspvalid = 1'b0;
         bus.rsperror = 1'b0;
         if (k == err_word) begin
            sha_dv = 1'b0;
            check("err_pulse", {err, blk_ready, bus.reqvalid, sha_process}, 4'b1100);
            repeat (4) begin
               @(negedge clk);
               check("after_err", {err, bus.reqvalid, sha_process}, 3'b000);
            end
            return;
         end
      end
      check("process", {sha_process, sha_ack, err}, 3'b100);
      noise();
      @(negedge clk);
      sha_dv = 1'b0;
      check("process_once", {sha_process, sha_ack}, 2'b00);
      if (no_dig) begin
         for (int i = 1; i <= TO; i++) begin
            @(negedge clk);
            check("timeout", {err, sha_ack, digest_valid}, {i == TO, 2'b00});
         end
         check("timeout_idle", blk_ready, 1'b1);
         return;
      end
      repeat (core_lat) begin
         check("wait_dig", {sha_ack, err}, 2'b00);
         @(negedge clk);
      end
      sha_digest = dig;
      sha_dv     = 1'b1;
      @(negedge clk);
      sha_dv     = 1'b0;
      sha_digest = ~dig;
      check("ack", {sha_ack, digest_valid}, 2'b10);
      @(negedge clk);
      check("ack_once", sha_ack, 1'b0);
      repeat (out_stall) begin
         check("out_hold", {digest_valid, digest}, {1'b1, dig});
         @(negedge clk);
      end
      check("out", {digest_valid, digest}, {1'b1, dig});
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      check("out_done", {digest_valid, blk_ready, digest}, {2'b01, dig});
   endtask

   initial begin
      logic [511:0] b;
      bus.reqready = 1'b0;
      bus.rspvalid = 1'b0;
      bus.rsperror = 1'b0;
      bus.rspdata  = '0;

      repeat (3) begin
         @(negedge clk);
         all_zero("reset");
      end
      rst = 1'b0;
      #1;
      check("post_reset", {blk_ready, bus.reqvalid, digest_valid}, 3'b100);

      for (int k = 0; k < NW; k++) b[k*DW +: DW] = 64'(k);
      run_block(b, rand_digest(), -1, 0, -1, -1, 3, 0, 1'b0);
      run_block(rand_block(), rand_digest(), 3, 5, -1, -1, 2, 0, 1'b0);
      run_block(rand_block(), rand_digest(), -1, 0, 2, -1, 0, 0, 1'b0);
      run_block(rand_block(), rand_digest(), -1, 0, -1, -1, 0, 0, 1'b1);
      run_block(rand_block(), rand_digest(), -1, 0, -1, 5, 0, 0, 1'b0);
      run_block(rand_block(), rand_digest(), -1, 0, -1, -1, 1, 4, 1'b0);
      run_block(rand_block(), rand_digest(), -1, 0, -1, -1, 0, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run_block(rand_block(), rand_digest(), $urandom_range(0, NW - 1),
                   $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(0, NW - 1) : -1,
                   -1, $urandom_range(0, 10), $urandom_range(0, 3), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
